// File: rtl/gate_fx_pkg.sv
// Shared fixed-point defaults, FSM state type and signed range helpers for gate_backprop.
package gate_fx_pkg;

    localparam int GFX_DATA_WIDTH  = 8;
    localparam int GFX_FRACT_WIDTH = 5;
    localparam int GFX_ACC_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } gate_state_t;

    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fx_sat_mul.sv
// Signed fixed-point multiply with floor shift; reduction is saturating when
// GATE_BACKPROP_SAT_EN is defined, two's-complement wrap otherwise.
module fx_sat_mul
    import gate_fx_pkg::*;
#(
    parameter int DATA_WIDTH  = GFX_DATA_WIDTH,
    parameter int FRACT_WIDTH = GFX_FRACT_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

`ifdef GATE_BACKPROP_SAT_EN
    logic signed [2*DATA_WIDTH-1:0] prod_sh;

    assign prod_sh = prod >>> FRACT_WIDTH;

    always_comb begin
        y = prod_sh[DATA_WIDTH-1:0];
        if (longint'(prod_sh) > smax(DATA_WIDTH)) begin
            y = DATA_WIDTH'(smax(DATA_WIDTH));
        end else if (longint'(prod_sh) < smin(DATA_WIDTH)) begin
            y = DATA_WIDTH'(smin(DATA_WIDTH));
        end
    end
`else
    assign y = DATA_WIDTH'(prod >>> FRACT_WIDTH);
`endif

endmodule

// File: rtl/gate_backprop.sv
// Backward pass of out = W0*X + W1*h_in + b through one shared multiplier.
// Optional macro GATE_BACKPROP_SAT_EN selects saturating products and accumulators.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand transfer
// MUL   | four multiplier cycles: dX, dh, dW0, dW1 (cnt counts 3 down to 0)
// DONE  | out_valid high, results held until out_ready
module gate_backprop
    import gate_fx_pkg::*;
#(
    parameter int DATA_WIDTH  = GFX_DATA_WIDTH,
    parameter int FRACT_WIDTH = GFX_FRACT_WIDTH,
    parameter int ACC_WIDTH   = GFX_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_WIDTH-1:0] d_out,
    input  logic signed [DATA_WIDTH-1:0] X,
    input  logic signed [DATA_WIDTH-1:0] h_in,
    input  logic signed [DATA_WIDTH-1:0] W0,
    input  logic signed [DATA_WIDTH-1:0] W1,
    input  logic                        acc_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_WIDTH-1:0] dX,
    output logic signed [DATA_WIDTH-1:0] dh,
    output logic signed [ACC_WIDTH-1:0]  dW0_acc,
    output logic signed [ACC_WIDTH-1:0]  dW1_acc,
    output logic signed [ACC_WIDTH-1:0]  db_acc
);

    gate_state_t state, state_nxt;
    logic [1:0] cnt;
    logic signed [DATA_WIDTH-1:0] d_out_r, x_r, h_r, w0_r, w1_r;
    logic signed [DATA_WIDTH-1:0] mul_b, mul_y, pw0;
    logic accept, mul_last;

    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0]  acc,
        input logic signed [DATA_WIDTH-1:0] v
    );
`ifdef GATE_BACKPROP_SAT_EN
        logic signed [ACC_WIDTH:0] s;
        s = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(v);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? ACC_WIDTH'(smin(ACC_WIDTH)) : ACC_WIDTH'(smax(ACC_WIDTH));
        end
        return s[ACC_WIDTH-1:0];
`else
        return acc + ACC_WIDTH'(v);
`endif
    endfunction

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_last  = (state == MUL) && (cnt == 2'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (cnt == 2'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // d_out is the common factor of every product; only the second operand is muxed
    always_comb begin
        mul_b = h_r;
        case (cnt)
            2'd3:    mul_b = w0_r;
            2'd2:    mul_b = w1_r;
            2'd1:    mul_b = x_r;
            default: mul_b = h_r;
        endcase
    end

    fx_sat_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_mul (
        .a(d_out_r),
        .b(mul_b),
        .y(mul_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            d_out_r <= '0;
            x_r     <= '0;
            h_r     <= '0;
            w0_r    <= '0;
            w1_r    <= '0;
            pw0     <= '0;
            dX      <= '0;
            dh      <= '0;
            dW0_acc <= '0;
            dW1_acc <= '0;
            db_acc  <= '0;
        end else begin
            if (accept) begin
                d_out_r <= d_out;
                x_r     <= X;
                h_r     <= h_in;
                w0_r    <= W0;
                w1_r    <= W1;
                cnt     <= 2'd3;
            end else if (state == MUL) begin
                cnt <= cnt - 2'd1;
            end

            if (state == MUL) begin
                case (cnt)
                    2'd3:    dX  <= mul_y;
                    2'd2:    dh  <= mul_y;
                    2'd1:    pw0 <= mul_y;
                    default: ;
                endcase
            end

            // the dW1 product is still on the multiplier output at the last MUL edge
            if (acc_clr) begin
                dW0_acc <= '0;
                dW1_acc <= '0;
                db_acc  <= '0;
            end else if (mul_last) begin
                dW0_acc <= acc_add(dW0_acc, pw0);
                dW1_acc <= acc_add(dW1_acc, mul_y);
                db_acc  <= acc_add(db_acc, d_out_r);
            end
        end
    end

endmodule
